// File: rtl/sdc_wb_regs_pkg.sv
// Shared definitions for the SD host controller register file.
// Holds the register address map, event bit indices, COMMAND field
// positions and a byte-lane merge helper used by the write path.
package sdc_regs_pkg;

    // Register byte addresses (bits [1:0] are always zero)
    localparam logic [7:0] ADDR_ARGUMENT        = 8'h00;
    localparam logic [7:0] ADDR_COMMAND         = 8'h04;
    localparam logic [7:0] ADDR_RESP0           = 8'h08;
    localparam logic [7:0] ADDR_RESP1           = 8'h0C;
    localparam logic [7:0] ADDR_RESP2           = 8'h10;
    localparam logic [7:0] ADDR_RESP3           = 8'h14;
    localparam logic [7:0] ADDR_DATA_TIMEOUT    = 8'h18;
    localparam logic [7:0] ADDR_CONTROL         = 8'h1C;
    localparam logic [7:0] ADDR_CMD_TIMEOUT     = 8'h20;
    localparam logic [7:0] ADDR_CLOCK_DIVIDER   = 8'h24;
    localparam logic [7:0] ADDR_RESET           = 8'h28;
    localparam logic [7:0] ADDR_VOLTAGE         = 8'h2C;
    localparam logic [7:0] ADDR_CAPABILITIES    = 8'h30;
    localparam logic [7:0] ADDR_CMD_EVT_STATUS  = 8'h34;
    localparam logic [7:0] ADDR_CMD_EVT_ENABLE  = 8'h38;
    localparam logic [7:0] ADDR_DATA_EVT_STATUS = 8'h3C;
    localparam logic [7:0] ADDR_DATA_EVT_ENABLE = 8'h40;
    localparam logic [7:0] ADDR_BLOCK_SIZE      = 8'h44;
    localparam logic [7:0] ADDR_BLOCK_COUNT     = 8'h48;
    localparam logic [7:0] ADDR_DMA_ADDR        = 8'h60;

    localparam int unsigned EVT_W = 5;

    // Command event bits
    localparam int unsigned CMD_EVT_COMPLETE = 0;
    localparam int unsigned CMD_EVT_ERROR    = 1;
    localparam int unsigned CMD_EVT_TIMEOUT  = 2;
    localparam int unsigned CMD_EVT_CRC      = 3;
    localparam int unsigned CMD_EVT_INDEX    = 4;

    // Data event bits
    localparam int unsigned DATA_EVT_COMPLETE = 0;
    localparam int unsigned DATA_EVT_ERROR    = 1;
    localparam int unsigned DATA_EVT_TIMEOUT  = 2;
    localparam int unsigned DATA_EVT_CRC      = 3;
    localparam int unsigned DATA_EVT_FIFO     = 4;

    // COMMAND register field positions
    localparam int unsigned CMD_OPCODE_MSB = 13;
    localparam int unsigned CMD_OPCODE_LSB = 8;
    localparam int unsigned CMD_XFER_MSB   = 6;
    localparam int unsigned CMD_XFER_LSB   = 5;
    localparam int unsigned CMD_RSP_MSB    = 2;
    localparam int unsigned CMD_RSP_LSB    = 0;

    // Replace each byte of old_v whose lane enable is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
        logic [31:0] r;
        r = old_v;
        for (int unsigned n = 0; n < 4; n++) begin
            if (sel[n]) r[8*n +: 8] = new_v[8*n +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sdc_wb_regs_if.sv
// Wishbone B4 classic bus bundle for the register file.
// master: drives address/data/strobes; slave: returns read data and ack.
interface sdc_wb_regs_if;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [7:0]  wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    modport master (
        output wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_dat_i, wb_adr_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/sdc_evt_reg.sv
// 5-bit event status register: bus write-zero-to-clear plus hardware set.
// Ports: clk, reset_n (async low), wr_en_i/wr_dat_i (bus write, ANDed in),
//        set_i (event pulses, ORed in afterwards), status_o (stored flags).
module sdc_evt_reg
    import sdc_regs_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  logic [EVT_W-1:0] wr_dat_i,
    input  logic [EVT_W-1:0] set_i,
    output logic [EVT_W-1:0] status_o
);

    logic [EVT_W-1:0] status_q;
    logic [EVT_W-1:0] status_d;

    // Set is applied after the clear so a coincident event is never lost.
    always_comb begin
        status_d = status_q;
        if (wr_en_i) status_d = status_q & wr_dat_i;
        status_d = status_d | set_i;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) status_q <= '0;
        else          status_q <= status_d;
    end

    assign status_o = status_q;

endmodule

// File: rtl/sdc_wb_regs.sv
// SD host controller register file, Wishbone B4 classic slave.
// Ports: clk/reset_n (async low); wb (slave modport: 32-bit data, 8-bit byte
//        address, byte selects, single-cycle registered ack);
//        configuration outputs to the command/data engines; rsp_in/rsp_valid
//        response capture; cmd_evt/data_evt event pulses; int_cmd/int_data.
module sdc_wb_regs
    import sdc_regs_pkg::*;
#(
    parameter logic [31:0] CAPABILITIES  = 32'h0000_0000,
    parameter logic [31:0] VOLTAGE       = 32'h0000_0F00,
    parameter logic [11:0] BLKSIZE_RESET = 12'd511
) (
    input  logic         clk,
    input  logic         reset_n,
    sdc_wb_regs_if.slave wb,
    output logic [31:0]  argument,
    output logic [13:0]  command,
    output logic         cmd_start,
    output logic [23:0]  data_timeout,
    output logic [23:0]  cmd_timeout,
    output logic         bus_width_4,
    output logic [7:0]   clk_divider,
    output logic         soft_rst,
    output logic [11:0]  block_size,
    output logic [15:0]  block_count,
    output logic [31:0]  dma_addr,
    input  logic [127:0] rsp_in,
    input  logic         rsp_valid,
    input  logic [4:0]   cmd_evt,
    input  logic [4:0]   data_evt,
    output logic         int_cmd,
    output logic         int_data
);

    logic        ack_q, cmd_start_q;
    logic [31:0] dat_q;
    logic        access, wr;
    logic [7:0]  adr_w;
    logic [31:0] rd_val, merged;

    logic [31:0] argument_q,     argument_d;
    logic [13:0] command_q,      command_d;
    logic [23:0] data_timeout_q, data_timeout_d;
    logic        control_q,      control_d;
    logic [23:0] cmd_timeout_q,  cmd_timeout_d;
    logic [7:0]  clk_div_q,      clk_div_d;
    logic        reset_q,        reset_d;
    logic [4:0]  cmd_en_q,       cmd_en_d;
    logic [4:0]  data_en_q,      data_en_d;
    logic [11:0] blk_size_q,     blk_size_d;
    logic [15:0] blk_count_q,    blk_count_d;
    logic [31:0] dma_addr_q,     dma_addr_d;
    logic [31:0] rsp_q [4];
    logic [4:0]  cmd_status, data_status;

    assign access = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
    assign wr     = access & wb.wb_we_i;
    assign adr_w  = {wb.wb_adr_i[7:2], 2'b00};

    always_comb begin
        rd_val = '0;
        unique case (adr_w)
            ADDR_ARGUMENT:        rd_val = argument_q;
            ADDR_COMMAND:         rd_val = {18'd0, command_q};
            ADDR_RESP0:           rd_val = rsp_q[0];
            ADDR_RESP1:           rd_val = rsp_q[1];
            ADDR_RESP2:           rd_val = rsp_q[2];
            ADDR_RESP3:           rd_val = rsp_q[3];
            ADDR_DATA_TIMEOUT:    rd_val = {8'd0, data_timeout_q};
            ADDR_CONTROL:         rd_val = {31'd0, control_q};
            ADDR_CMD_TIMEOUT:     rd_val = {8'd0, cmd_timeout_q};
            ADDR_CLOCK_DIVIDER:   rd_val = {24'd0, clk_div_q};
            ADDR_RESET:           rd_val = {31'd0, reset_q};
            ADDR_VOLTAGE:         rd_val = VOLTAGE;
            ADDR_CAPABILITIES:    rd_val = CAPABILITIES;
            ADDR_CMD_EVT_STATUS:  rd_val = {27'd0, cmd_status};
            ADDR_CMD_EVT_ENABLE:  rd_val = {27'd0, cmd_en_q};
            ADDR_DATA_EVT_STATUS: rd_val = {27'd0, data_status};
            ADDR_DATA_EVT_ENABLE: rd_val = {27'd0, data_en_q};
            ADDR_BLOCK_SIZE:      rd_val = {20'd0, blk_size_q};
            ADDR_BLOCK_COUNT:     rd_val = {16'd0, blk_count_q};
            ADDR_DMA_ADDR:        rd_val = dma_addr_q;
            default:              rd_val = '0;
        endcase
    end

    // The stored value (already zero-extended by the read mux) is merged with
    // the enabled write bytes, then truncated back to the register width.
    assign merged = be_merge(rd_val, wb.wb_dat_i, wb.wb_sel_i);

    always_comb begin
        argument_d     = argument_q;
        command_d      = command_q;
        data_timeout_d = data_timeout_q;
        control_d      = control_q;
        cmd_timeout_d  = cmd_timeout_q;
        clk_div_d      = clk_div_q;
        reset_d        = reset_q;
        cmd_en_d       = cmd_en_q;
        data_en_d      = data_en_q;
        blk_size_d     = blk_size_q;
        blk_count_d    = blk_count_q;
        dma_addr_d     = dma_addr_q;
        if (wr) begin
            unique case (adr_w)
                ADDR_ARGUMENT:        argument_d     = merged;
                ADDR_COMMAND:         command_d      = merged[13:0];
                ADDR_DATA_TIMEOUT:    data_timeout_d = merged[23:0];
                ADDR_CONTROL:         control_d      = merged[0];
                ADDR_CMD_TIMEOUT:     cmd_timeout_d  = merged[23:0];
                ADDR_CLOCK_DIVIDER:   clk_div_d      = merged[7:0];
                ADDR_RESET:           reset_d        = merged[0];
                ADDR_CMD_EVT_ENABLE:  cmd_en_d       = merged[4:0];
                ADDR_DATA_EVT_ENABLE: data_en_d      = merged[4:0];
                ADDR_BLOCK_SIZE:      blk_size_d     = merged[11:0];
                ADDR_BLOCK_COUNT:     blk_count_d    = merged[15:0];
                ADDR_DMA_ADDR:        dma_addr_d     = merged;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_q          <= 1'b0;
            dat_q          <= '0;
            cmd_start_q    <= 1'b0;
            argument_q     <= '0;
            command_q      <= '0;
            data_timeout_q <= '0;
            control_q      <= 1'b0;
            cmd_timeout_q  <= '0;
            clk_div_q      <= '0;
            reset_q        <= 1'b0;
            cmd_en_q       <= '0;
            data_en_q      <= '0;
            blk_size_q     <= BLKSIZE_RESET;
            blk_count_q    <= '0;
            dma_addr_q     <= '0;
            for (int unsigned k = 0; k < 4; k++) rsp_q[k] <= '0;
        end else begin
            ack_q          <= access;
            dat_q          <= access ? rd_val : '0;
            cmd_start_q    <= wr && (adr_w == ADDR_ARGUMENT);
            argument_q     <= argument_d;
            command_q      <= command_d;
            data_timeout_q <= data_timeout_d;
            control_q      <= control_d;
            cmd_timeout_q  <= cmd_timeout_d;
            clk_div_q      <= clk_div_d;
            reset_q        <= reset_d;
            cmd_en_q       <= cmd_en_d;
            data_en_q      <= data_en_d;
            blk_size_q     <= blk_size_d;
            blk_count_q    <= blk_count_d;
            dma_addr_q     <= dma_addr_d;
            if (rsp_valid) begin
                for (int unsigned k = 0; k < 4; k++) rsp_q[k] <= rsp_in[32*k +: 32];
            end
        end
    end

    sdc_evt_reg u_cmd_evt (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en_i  (wr && (adr_w == ADDR_CMD_EVT_STATUS) && wb.wb_sel_i[0]),
        .wr_dat_i (wb.wb_dat_i[4:0]),
        .set_i    (cmd_evt),
        .status_o (cmd_status)
    );

    sdc_evt_reg u_data_evt (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en_i  (wr && (adr_w == ADDR_DATA_EVT_STATUS) && wb.wb_sel_i[0]),
        .wr_dat_i (wb.wb_dat_i[4:0]),
        .set_i    (data_evt),
        .status_o (data_status)
    );

    assign wb.wb_ack_o  = ack_q;
    assign wb.wb_dat_o  = dat_q;
    assign cmd_start    = cmd_start_q;
    assign argument     = argument_q;
    assign command      = command_q;
    assign data_timeout = data_timeout_q;
    assign cmd_timeout  = cmd_timeout_q;
    assign bus_width_4  = control_q;
    assign clk_divider  = clk_div_q;
    assign soft_rst     = reset_q;
    assign block_size   = blk_size_q;
    assign block_count  = blk_count_q;
    assign dma_addr     = dma_addr_q;
    assign int_cmd      = |(cmd_status & cmd_en_q);
    assign int_data     = |(data_status & data_en_q);

endmodule

// File: tb/tb_sdc_wb_regs.sv
// Self-checking bench for sdc_wb_regs: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a register-map model.
module tb_sdc_wb_regs;
    import sdc_regs_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    sdc_wb_regs_if wb ();

    logic [31:0]  argument, dma_addr;
    logic [13:0]  command;
    logic         cmd_start, bus_width_4, soft_rst, rsp_valid, int_cmd, int_data;
    logic [23:0]  data_timeout, cmd_timeout;
    logic [7:0]   clk_divider;
    logic [11:0]  block_size;
    logic [15:0]  block_count;
    logic [127:0] rsp_in;
    logic [4:0]   cmd_evt, data_evt;

    sdc_wb_regs #(
        .CAPABILITIES  (32'h0000_0000),
        .VOLTAGE       (32'h0000_0F00),
        .BLKSIZE_RESET (12'd511)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wb           (wb),
        .argument     (argument),
        .command      (command),
        .cmd_start    (cmd_start),
        .data_timeout (data_timeout),
        .cmd_timeout  (cmd_timeout),
        .bus_width_4  (bus_width_4),
        .clk_divider  (clk_divider),
        .soft_rst     (soft_rst),
        .block_size   (block_size),
        .block_count  (block_count),
        .dma_addr     (dma_addr),
        .rsp_in       (rsp_in),
        .rsp_valid    (rsp_valid),
        .cmd_evt      (cmd_evt),
        .data_evt     (data_evt),
        .int_cmd      (int_cmd),
        .int_data     (int_data)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: register map by word index ----------
    logic [31:0] m_reg [0:63];
    logic [31:0] m_rsp [0:3];

    function automatic logic [31:0] wmask(input int unsigned idx);
        case (idx)
            0, 24:          return 32'hFFFF_FFFF;
            1:              return 32'h0000_3FFF;
            6, 8:           return 32'h00FF_FFFF;
            7, 10:          return 32'h0000_0001;
            9:              return 32'h0000_00FF;
            13, 14, 15, 16: return 32'h0000_001F;
            17:             return 32'h0000_0FFF;
            18:             return 32'h0000_FFFF;
            default:        return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input int unsigned idx);
        if (idx >= 2 && idx <= 5) return m_rsp[idx-2];
        if (idx == 11) return 32'h0000_0F00;
        if (idx == 12) return 32'h0000_0000;
        return m_reg[idx] & wmask(idx);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_reg[i] = 32'h0;
        for (int i = 0; i < 4; i++) m_rsp[i] = 32'h0;
        m_reg[17] = 32'd511;
    endtask

    task automatic model_access(input logic we, input logic [7:0] adr, input logic [3:0] sel,
                                input logic [31:0] dat, input logic [4:0] cevt, input logic [4:0] devt,
                                input logic rv, input logic [127:0] rin,
                                output logic [31:0] exp_rd, output logic exp_start);
        int unsigned idx;
        idx = adr[7:2];
        exp_rd = model_read(idx);
        exp_start = we && (idx == 0);
        if (we) begin
            if (idx == 13 || idx == 15) begin
                if (sel[0]) m_reg[idx] = m_reg[idx] & {27'd0, dat[4:0]};
            end else begin
                for (int n = 0; n < 4; n++)
                    if (sel[n]) m_reg[idx][8*n +: 8] = dat[8*n +: 8];
                m_reg[idx] = m_reg[idx] & wmask(idx);
            end
        end
        m_reg[13] = m_reg[13] | {27'd0, cevt};
        m_reg[15] = m_reg[15] | {27'd0, devt};
        if (rv) for (int k = 0; k < 4; k++) m_rsp[k] = rin[32*k +: 32];
    endtask

    function automatic logic [255:0] model_ports();
        return {92'd0, m_reg[0], m_reg[1][13:0], m_reg[6][23:0], m_reg[8][23:0], m_reg[7][0],
                m_reg[9][7:0], m_reg[10][0], m_reg[17][11:0], m_reg[18][15:0], m_reg[24]};
    endfunction

    function automatic logic [255:0] dut_ports();
        return {92'd0, argument, command, data_timeout, cmd_timeout, bus_width_4,
                clk_divider, soft_rst, block_size, block_count, dma_addr};
    endfunction

    // ---------------- bus driver ----------------
    task automatic xfer(input logic we, input logic [7:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                        input logic [4:0] cevt, input logic [4:0] devt, input logic rv, input logic [127:0] rin,
                        output logic [31:0] rd, output logic got_ack, output logic got_start);
        @(negedge clk);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
        wb.wb_adr_i = adr; wb.wb_sel_i = sel; wb.wb_dat_i = dat;
        cmd_evt = cevt; data_evt = devt; rsp_valid = rv; rsp_in = rin;
        @(posedge clk); #1;
        got_ack = wb.wb_ack_o; rd = wb.wb_dat_o; got_start = cmd_start;
        @(negedge clk);
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        cmd_evt = '0; data_evt = '0; rsp_valid = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [7:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                       input logic [4:0] cevt, input logic [4:0] devt, input logic rv, input logic [127:0] rin,
                       output logic [31:0] rd);
        logic ack, st, est;
        logic [31:0] erd;
        xfer(we, adr, sel, dat, cevt, devt, rv, rin, rd, ack, st);
        model_access(we, adr, sel, dat, cevt, devt, rv, rin, erd, est);
        chk("ack", {255'd0, ack}, 256'd1);
        if (!we) chk("rdata", {224'd0, rd}, {224'd0, erd});
        chk("cmd_start", {255'd0, st}, {255'd0, est});
        chk("ports", dut_ports(), model_ports());
        chk("int_cmd", {255'd0, int_cmd}, {255'd0, |(m_reg[13][4:0] & m_reg[14][4:0])});
        chk("int_data", {255'd0, int_data}, {255'd0, |(m_reg[15][4:0] & m_reg[16][4:0])});
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] exp;
    } vec_t;

    logic [7:0] alist [0:22] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h24,
                                 8'h28, 8'h2C, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h40, 8'h44, 8'h48, 8'h60,
                                 8'h4C, 8'h58, 8'hFC};

    initial begin
        vec_t vecs[$];
        logic [31:0] rd;
        logic ack, st;

        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = '0; wb.wb_sel_i = '0; wb.wb_dat_i = '0;
        cmd_evt = '0; data_evt = '0; rsp_valid = 1'b0; rsp_in = '0;
        model_reset();

        // reset state
        #12;
        chk("rst_ack", {255'd0, wb.wb_ack_o}, 256'd0);
        chk("rst_dat", {224'd0, wb.wb_dat_o}, 256'd0);
        chk("rst_start", {255'd0, cmd_start}, 256'd0);
        chk("rst_blksize", {244'd0, block_size}, 256'h1FF);
        chk("rst_softrst", {255'd0, soft_rst}, 256'd0);
        @(negedge clk); reset_n = 1'b1;

        // directed vector table
        vecs.push_back(vec_t'{1'b0, 8'h44, 4'hF, 32'h0, 32'h0000_01FF});
        vecs.push_back(vec_t'{1'b0, 8'h18, 4'hF, 32'h0, 32'h0});
        vecs.push_back(vec_t'{1'b0, 8'h24, 4'hF, 32'h0, 32'h0});
        vecs.push_back(vec_t'{1'b0, 8'h34, 4'hF, 32'h0, 32'h0});
        vecs.push_back(vec_t'{1'b0, 8'h2C, 4'hF, 32'h0, 32'h0000_0F00});
        vecs.push_back(vec_t'{1'b1, 8'h18, 4'b0101, 32'hAABB_CCDD, 32'h0});
        vecs.push_back(vec_t'{1'b0, 8'h18, 4'hF, 32'h0, 32'h00BB_00DD});
        vecs.push_back(vec_t'{1'b1, 8'h24, 4'hF, 32'hFFFF_FFA5, 32'h0});
        vecs.push_back(vec_t'{1'b0, 8'h24, 4'hF, 32'h0, 32'h0000_00A5});
        vecs.push_back(vec_t'{1'b1, 8'h1C, 4'hF, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back(vec_t'{1'b0, 8'h1C, 4'hF, 32'h0, 32'h0000_0001});
        vecs.push_back(vec_t'{1'b1, 8'h30, 4'hF, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back(vec_t'{1'b0, 8'h30, 4'hF, 32'h0, 32'h0});
        vecs.push_back(vec_t'{1'b1, 8'h44, 4'b0011, 32'hFFFF_F123, 32'h0});
        vecs.push_back(vec_t'{1'b0, 8'h44, 4'hF, 32'h0, 32'h0000_0123});
        vecs.push_back(vec_t'{1'b1, 8'h08, 4'hF, 32'h5555_5555, 32'h0});
        vecs.push_back(vec_t'{1'b0, 8'h08, 4'hF, 32'h0, 32'h0});
        foreach (vecs[i]) begin
            txn(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, 5'd0, 5'd0, 1'b0, 128'd0, rd);
            if (!vecs[i].we) chk("vec_rd", {224'd0, rd}, {224'd0, vecs[i].exp});
        end
        chk("data_timeout", {232'd0, data_timeout}, {232'd0, 24'hBB00DD});

        // W0C with simultaneous hardware set
        txn(1'b0, 8'h34, 4'hF, 32'h0, 5'b10011, 5'd0, 1'b0, 128'd0, rd);
        txn(1'b1, 8'h34, 4'hF, 32'h0000_0001, 5'b00100, 5'd0, 1'b0, 128'd0, rd);
        txn(1'b0, 8'h34, 4'hF, 32'h0, 5'd0, 5'd0, 1'b0, 128'd0, rd);
        chk("w0c_status", {224'd0, rd}, 256'h05);
        txn(1'b1, 8'h38, 4'hF, 32'h0000_0004, 5'd0, 5'd0, 1'b0, 128'd0, rd);
        chk("int_cmd_set", {255'd0, int_cmd}, 256'd1);

        // data event captured without any bus activity
        @(negedge clk); data_evt = 5'b01000;
        @(negedge clk); data_evt = 5'd0;
        m_reg[15] = m_reg[15] | 32'h8;
        txn(1'b0, 8'h3C, 4'hF, 32'h0, 5'd0, 5'd0, 1'b0, 128'd0, rd);
        chk("idle_evt", {224'd0, rd}, 256'h08);

        // response load: a same-cycle read returns the old word
        txn(1'b0, 8'h0C, 4'hF, 32'h0, 5'd0, 5'd0, 1'b1, {32'hD3, 32'hC2, 32'hB1, 32'hA0}, rd);
        chk("rsp_old", {224'd0, rd}, 256'd0);
        txn(1'b0, 8'h0C, 4'hF, 32'h0, 5'd0, 5'd0, 1'b0, 128'd0, rd);
        chk("rsp_new", {224'd0, rd}, 256'hB1);

        // command issue
        txn(1'b1, 8'h04, 4'hF, 32'h0000_0119, 5'd0, 5'd0, 1'b0, 128'd0, rd);
        txn(1'b1, 8'h00, 4'hF, 32'h1234_5678, 5'd0, 5'd0, 1'b0, 128'd0, rd);
        chk("argument", {224'd0, argument}, 256'h1234_5678);
        chk("opcode", {250'd0, command[CMD_OPCODE_MSB:CMD_OPCODE_LSB]}, 256'd1);
        @(posedge clk); #1;
        chk("start_once", {255'd0, cmd_start}, 256'd0);

        // ack cadence on a held strobe to an unmapped address
        @(negedge clk);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = 8'h50; wb.wb_sel_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("cadence_ack", {255'd0, wb.wb_ack_o}, {255'd0, (i % 2) == 1});
            chk("cadence_dat", {224'd0, wb.wb_dat_o}, 256'd0);
            @(negedge clk);
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;

        // reset asserted before the write can be acknowledged
        txn(1'b1, 8'h60, 4'hF, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0, 128'd0, rd);
        @(negedge clk);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
        wb.wb_adr_i = 8'h60; wb.wb_sel_i = 4'hF; wb.wb_dat_i = 32'h1111_1111;
        #2 reset_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_mid_ack", {255'd0, wb.wb_ack_o}, 256'd0);
        end
        @(negedge clk);
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        reset_n = 1'b1;
        txn(1'b0, 8'h60, 4'hF, 32'h0, 5'd0, 5'd0, 1'b0, 128'd0, rd);
        chk("rst_mid_dma", {224'd0, rd}, 256'd0);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [7:0] a;
            logic [4:0] ce, de;
            logic rv;
            a = alist[$urandom_range(0, 22)] | 8'($urandom_range(0, 3));
            ce = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            de = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            rv = ($urandom_range(0, 3) == 0);
            txn(1'($urandom), a, 4'($urandom), $urandom, ce, de, rv,
                {$urandom, $urandom, $urandom, $urandom}, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
